mem_arbiter: RTL

Two-port arbiter that shares the single-port `Memory` (14-bit byte address, 32-bit data, 1-cycle registered read) between the CPU and a second bus master, e.g. a firmware loader or DMA. The arbiter sits between the masters and `Memory` inside `Soc`. It grants one transaction per cycle using round-robin with an optional bounded lock for bursts. It also routes the registered read data back to the master that issued the read.

---
 rtl/mem_bus_pkg.sv | 10 +
 rtl/mem_arbiter_if.sv | 12 +
 rtl/mem_arbiter_rr_lock_arb2.sv | 35 +++
 rtl/mem_arbiter.sv | 48 ++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: memory bus encodings, master ids and default widths
package mem_bus_pkg;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam logic [1:0] WSIZE_B = 2'b01;
  localparam logic [1:0] WSIZE_H = 2'b10;
  localparam logic [1:0] WSIZE_W = 2'b11;
  localparam int M_CPU = 0;
  localparam int M_AUX = 1;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one master's request and read-return port into the arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_bus_pkg::ADDR_W,
  parameter int DATA_W = mem_bus_pkg::DATA_W
);
  logic req, we, lock, gnt, rvalid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [1:0] wsize;
  modport master(output req, we, lock, addr, wdata, wsize, input gnt, rvalid, rdata);
  modport slave(input req, we, lock, addr, wdata, wsize, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter_rr_lock_arb2.sv
// rr_lock_arb2: two-way round-robin arbiter with a lock bounded to MAX_BURST grants
module rr_lock_arb2 #(
  parameter int MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);
  localparam int CW = $clog2(MAX_BURST + 1);
  logic last, owner, lock_act, win, keep, hold;
  logic [CW-1:0] burst_cnt, cnt_n;
  // the grant that takes the lock already counts toward the burst if the other side waits
  always_comb begin
    win = (req == 2'b11) ? (lock_act ? owner : ~last) : req[1];
    gnt = (resetn && |req) ? (win ? 2'b10 : 2'b01) : 2'b00;
    keep = |gnt & lock[win];
    cnt_n = ((lock_act && owner == win) ? burst_cnt : '0) + CW'(req[~win]);
    hold = keep && (cnt_n != CW'(MAX_BURST));
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last <= 1'b1;
      owner <= 1'b0;
      lock_act <= 1'b0;
      burst_cnt <= '0;
    end else begin
      if (|gnt) last <= win;
      if (keep) owner <= win;
      lock_act <= hold;
      burst_cnt <= hold ? cnt_n : '0;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between two masters with read-return routing
module mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              resetn,
  mem_arbiter_if.slave      m0,
  mem_arbiter_if.slave      m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  output logic              mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_wsize,
  input  logic [DATA_W-1:0] mem_rdata
);
  import mem_bus_pkg::*;
  logic [1:0] gnt, rd_pend;
  logic sel, we;
  rr_lock_arb2 #(.MAX_BURST(MAX_BURST)) arb (
    .clk(clk),
    .resetn(resetn),
    .req({m1.req, m0.req}),
    .lock({m1.lock, m0.lock}),
    .gnt(gnt)
  );
  // with no grant sel is 0, so mem_addr rests on m0
  always_comb begin
    sel = gnt[M_AUX];
    we = sel ? m1.we : m0.we;
    mem_addr = sel ? m1.addr : m0.addr;
    mem_wdata = sel ? m1.wdata : m0.wdata;
    mem_wsize = sel ? m1.wsize : m0.wsize;
    mem_rstrb = |gnt & ~we;
    mem_wstrb = |gnt & we;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_pend <= '0;
    else rd_pend <= gnt & ~{m1.we, m0.we};
  end
  assign m0.gnt = gnt[M_CPU];
  assign m1.gnt = gnt[M_AUX];
  assign m0.rvalid = rd_pend[M_CPU];
  assign m1.rvalid = rd_pend[M_AUX];
  assign m0.rdata = mem_rdata;
  assign m1.rdata = mem_rdata;
endmodule
